// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display arbiter
//
// Contents:
//   disp_state_e      : arbiter FSM states (IDLE, HOLD, OPEN)
//   DIGIT_W           : bits per hex digit
//   DISP_W            : width of the 4-digit display word
//   DEFAULT_IDLE_DATA : value shown while nobody owns the display

package disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,    // nobody owns the display
        HOLD = 2'd1,    // owner is inside its minimum hold window
        OPEN = 2'd2     // hold window served; owner keeps it until someone else asks
    } disp_state_e;

    localparam int DIGIT_W = 4;
    localparam int DISP_W  = 4 * DIGIT_W;

    localparam logic [DISP_W-1:0] DEFAULT_IDLE_DATA = 16'h0000;

endpackage

// File: rtl/disp_arbiter_rr_pick.sv
// rtl/disp_arbiter_rr_pick.sv - combinational round-robin requester picker
//
// Ports:
//   req      in  N_REQ   request mask
//   rr_ptr   in  IDX_W   index where the search starts (must be < N_REQ)
//   excl_en  in  1       when high, excl_idx is never picked
//   excl_idx in  IDX_W   index to skip (normally the current owner)
//   pick     out IDX_W   first eligible requester at or after rr_ptr, wrapping
//   found    out 1       high when pick is valid

module disp_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic             excl_en,
    input  logic [IDX_W-1:0] excl_idx,
    output logic [IDX_W-1:0] pick,
    output logic             found
);

    int               pos;
    logic [IDX_W-1:0] idx;

    // Walk the ring starting at rr_ptr; the first eligible hit wins. The
    // wrap is done with a subtract instead of a modulo so non-power-of-two
    // requester counts still wrap correctly.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = int'(rr_ptr) + i;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            idx = IDX_W'(pos);
            if (!found && req[idx] && !(excl_en && (idx == excl_idx))) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

endmodule

// File: rtl/disp_arbiter.sv
// rtl/disp_arbiter.sv - round-robin owner arbiter for the shared 4-digit hex display
//
// Shares one 16-bit display word between N_REQ requesters. Each owner keeps
// the display for at least HOLD_CYCLES clocks so the value stays readable,
// then the display rotates to the next waiting requester.
//
// Optional build macro: DISP_ARB_PRIO_EN
//   defined   : requester 0 is urgent; it wins in IDLE and preempts any other
//               owner at the next edge.
//   undefined : requester 0 is an ordinary round-robin participant.
//
// Ports:
//   clk        in  1            system clock
//   rst        in  1            asynchronous reset, active-high
//   req        in  N_REQ        per-requester level request
//   req_data   in  N_REQ*16     packed data, requester k at [k*16 +: 16]
//   gnt        out N_REQ        registered one-hot grant, zero when idle
//   owner      out clog2(N_REQ) current owner index, valid while busy
//   busy       out 1            high while someone owns the display
//   disp_data  out 16           registered display word

module disp_arbiter
    import disp_pkg::*;
#(
    parameter int                N_REQ       = 4,
    parameter int                HOLD_CYCLES = 50000000,
    parameter logic [DISP_W-1:0] IDLE_DATA   = DEFAULT_IDLE_DATA
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DISP_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      busy,
    output logic [DISP_W-1:0]         disp_data
);

    localparam int               IDX_W     = $clog2(N_REQ);
    localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    disp_state_e        state_q,     state_d;
    logic [N_REQ-1:0]   gnt_q,       gnt_d;
    logic [IDX_W-1:0]   owner_q,     owner_d;
    logic               busy_q,      busy_d;
    logic [DISP_W-1:0]  disp_data_q, disp_data_d;
    logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;

    logic [IDX_W-1:0]   pick;
    logic               found;
    logic               owner_req;
    logic [DISP_W-1:0]  owner_data;
    logic               do_grant;
    logic               do_idle;
    logic [IDX_W-1:0]   new_idx;

    // While someone owns the display the search skips the owner, so "found"
    // means "another requester is waiting".
    disp_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .excl_en  (state_q != IDLE),
        .excl_idx (owner_q),
        .pick     (pick),
        .found    (found)
    );

    assign owner_req = req[owner_q];

    // Constant-index mux avoids a variable-width part-select on req_data.
    always_comb begin
        owner_data = req_data[DISP_W-1:0];
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_data = req_data[k*DISP_W +: DISP_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        busy_d      = busy_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        disp_data_d = busy_q ? owner_data : IDLE_DATA;
        do_grant    = 1'b0;
        do_idle     = 1'b0;
        new_idx     = pick;

        case (state_q)
            IDLE: begin
                do_grant = found;
            end
            HOLD: begin
                // A dropped request ends ownership even inside the hold
                // window; a waiting requester takes over with no idle gap.
                if (!owner_req) begin
                    do_grant = found;
                    do_idle  = !found;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = OPEN;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            OPEN: begin
                // hold_cnt stays saturated here; only a grant clears it.
                if (!owner_req) begin
                    do_grant = found;
                    do_idle  = !found;
                end else begin
                    do_grant = found;
                end
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase

`ifdef DISP_ARB_PRIO_EN
        // Urgent requester 0 overrides both the round-robin pick and any
        // running hold window of another owner.
        if (req[0] && ((state_q == IDLE) || (owner_q != '0))) begin
            do_grant = 1'b1;
            do_idle  = 1'b0;
            new_idx  = '0;
        end
`endif

        if (do_grant) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            owner_d    = new_idx;
            gnt_d      = N_REQ'(1) << new_idx;
            busy_d     = 1'b1;
            rr_ptr_d   = (new_idx == LAST_IDX) ? '0 : new_idx + IDX_W'(1);
        end else if (do_idle) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            gnt_d      = '0;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            busy_q      <= 1'b0;
            disp_data_q <= IDLE_DATA;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            disp_data_q <= disp_data_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign busy      = busy_q;
    assign disp_data = disp_data_q;

endmodule

// File: doc/disp_arbiter.md
Name: disp_arbiter

Overview:
- Shares the single 4-digit hex display between up to N_REQ requesters. Example requesters: button counter, debug registers, status word.
- Round-robin grant with a minimum hold time, so each value stays readable before the display switches owner.
- Registered 16-bit output feeds the display multiplexer's data input directly; the display is untouched by this block.
- Sequential core: 3-state FSM, hold counter, round-robin pointer, one-hot grant handshake.

Parameters:
- N_REQ, 4, number of requesters; legal 2..8.
- HOLD_CYCLES, 50000000, minimum clk cycles an owner keeps the display (1 s at 50 MHz); must be >= 1.
- IDLE_DATA, 16'h0000, value driven to the display when nobody owns it.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  N_REQ  per-requester level request; held while display wanted
- req_data  in  N_REQ*16  packed data; requester k occupies bits [k*16 +: 16]
- gnt  out  N_REQ  one-hot grant, registered; all-zero when idle
- owner  out  $clog2(N_REQ)  index of current owner; valid only when busy=1
- busy  out  1  high while any requester owns the display
- disp_data  out  16  registered data to the display

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt=0, owner=0, busy=0, disp_data=IDLE_DATA, rr_ptr=0, hold_cnt=0.
- rr_ptr is the search start: after every grant it is set to owner+1, wrapping N_REQ-1 -> 0. Pick = first set req bit at or after rr_ptr, wrapping.
- States:
  - IDLE: if any req, grant the picked requester. Go to HOLD with hold_cnt=0; gnt/owner/busy update at that edge (1-cycle req->gnt latency).
  - HOLD: if req[owner]=0, release (see below). Else if hold_cnt==HOLD_CYCLES-1, go to OPEN. Else hold_cnt+1.
  - OPEN: if req[owner]=0, release. Else if any other req bit set, switch to the picked other requester and go to HOLD with hold_cnt=0. Else stay.
- Release: if any other req bit is set, hand over in the same edge (no idle gap) into HOLD with hold_cnt=0. Otherwise go to IDLE with gnt=0, busy=0.
- gnt never has more than one bit set. Owner changes in a single edge; no cycle with two grants.
- disp_data: registered each cycle. Equals req_data[owner] sampled the cycle before, so it tracks live data changes with 1-cycle latency. Equals IDLE_DATA the cycle after entering IDLE. First owner data appears 1 cycle after gnt.
- Requester dropping and re-raising req within one cycle while owner: treated as a release at the edge req was low.
- Simultaneous new requests in IDLE: round-robin pick from rr_ptr, never fixed priority.
- hold_cnt width $clog2(HOLD_CYCLES+1). Saturates in OPEN (not incremented).
- rst asserted mid-operation: all outputs return to reset values immediately; pending reqs are re-arbitrated from rr_ptr=0 after release.

Optional Feature:
- Macro DISP_ARB_PRIO_EN.
- Defined: requester 0 is urgent. If req[0] rises while another requester owns in HOLD or OPEN, preempt at the next edge: gnt=1<<0, owner=0, HOLD with hold_cnt=0, rr_ptr=1. In IDLE, requester 0 wins over any simultaneous request. Requester 0 itself obeys the normal hold rules once owner.
- Undefined: requester 0 is ordinary round-robin; no preemption logic synthesised.

Decomposition:
- Package disp_pkg: state enum typedef (IDLE, HOLD, OPEN); DIGIT_W=4; DISP_W=16; default IDLE_DATA constant.
- Sub-module rr_pick (combinational): inputs req mask, rr_ptr, exclude-owner enable plus owner index; outputs pick index and found flag. Instantiated once.

Test Plan (HOLD_CYCLES=4, N_REQ=4):
- Reset: rst=1 with req=4'b1111 -> gnt=0, busy=0, disp_data=0000 throughout; after release, gnt=0001 on first edge.
- Single request: req=0100, req_data[2]=16'hBEEF at edge E -> gnt=0100, owner=2, busy=1 at E+1; disp_data=BEEF at E+2; drop req at E+5 -> gnt=0 at E+6, disp_data=0000 at E+7.
- Hold and rotate: req=0011 from edge E -> gnt=0001 at E+1 through E+5 (4 HOLD cycles, then OPEN); gnt=0010 at E+6; back to 0001 four hold cycles after that.
- Early handover: requester 1 owns, req[3]=1 pending, req[1] drops in HOLD cycle 2 -> gnt=1000 on the next edge, no all-zero cycle, hold_cnt restarted.
- Live update: owner 2, req_data[2] changes 1234->5678 at edge E -> disp_data=5678 at E+1; no owner change.
- DISP_ARB_PRIO_EN: owner 2 in HOLD cycle 1, req[0] rises -> gnt=0001 next edge. Without the macro, gnt stays 0100 until hold expires.
- Reset mid-hold: rst pulsed while owner 3 -> gnt=0 immediately (async); after release, with req=1001, gnt=0001.
